// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state and recoded-digit enums, step/counter sizing helpers and
// the digit decode table.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } digit_t;

   // One radix-4 digit per step over WIDTH+2 extended bits.
   function automatic int booth_steps(input int width);
      return width / 2 + 1;
   endfunction

   // Bits needed to count 0..N inclusive.
   function automatic int booth_cnt_w(input int width);
      int n;
      int w;
      n = width / 2 + 1;
      w = 0;
      while ((1 << w) < (n + 1)) w++;
      return w;
   endfunction

   // Booth table for the triplet {q[1], q[0], cb}.
   function automatic digit_t booth_digit(input logic [2:0] trip);
      digit_t d;
      case (trip)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: turns the current multiplier triplet and the
// extended multiplicand into the E-bit addend for this step.
module booth_r4_recode
   import booth_pkg::*;
#(
   parameter int E = 34
) (
   input  logic [2:0]   trip,
   input  logic [E-1:0] m,
   output logic [E-1:0] addend
);

   digit_t       dig;
   logic [E-1:0] m2;

   assign dig = booth_digit(trip);
   assign m2  = {m[E-2:0], 1'b0};

   // Select 0, +-M or +-2M; negation is two's complement mod 2^E.
   always_comb begin
      addend = '0;
      case (dig)
         POS1:    addend = m;
         POS2:    addend = m2;
         NEG1:    addend = -m;
         NEG2:    addend = -m2;
         default: addend = '0;
      endcase
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Multi-cycle radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
// signed or unsigned per operation, one recoded digit per clock.
// Operands are extended by two bits (sign or zero) so the top digit
// makes unsigned full-range values come out right.
// Optional build macro BOOTH_MULT_ZERO_SKIP_EN: an operation with a zero
// operand bypasses RUN and completes the cycle after acceptance.
// WIDTH must be even and >= 4.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] mult,
   input  logic [WIDTH-1:0] multr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ZhighOut,
   output logic [WIDTH-1:0] ZlowOut
);

   localparam int E  = WIDTH + 2;
   localparam int N  = booth_steps(WIDTH);
   localparam int CW = booth_cnt_w(WIDTH);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   logic [1:0]        state;
   logic signed [E-1:0] acc;
   logic [E-1:0]      q;
   logic              cb;
   logic [E-1:0]      m_r;
   logic [CW-1:0]     cnt;

   logic [E-1:0]      addend;
   logic [E-1:0]      s;
   logic [2*E-1:0]    shifted;
   logic [E-1:0]      mult_ext;
   logic [E-1:0]      multr_ext;
   logic              zero_op;

   // Mode-dependent extension of both operands to E bits.
   assign mult_ext  = {{2{is_signed & mult[WIDTH-1]}}, mult};
   assign multr_ext = {{2{is_signed & multr[WIDTH-1]}}, multr};
   assign zero_op   = (mult == '0) || (multr == '0);

   booth_r4_recode #(.E(E)) u_recode (
      .trip   ({q[1:0], cb}),
      .m      (m_r),
      .addend (addend)
   );

   // Add the digit's addend and arithmetic-shift {acc,q} right by two.
   always_comb begin
      s       = acc + addend;
      shifted = {s[E-1], s[E-1], s, q[E-1:2]};
   end

   // Control FSM plus datapath registers; outputs are all registered.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= ST_IDLE;
         acc      <= '0;
         q        <= '0;
         cb       <= 1'b0;
         m_r      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ZhighOut <= '0;
         ZlowOut  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  acc <= '0;
                  q   <= multr_ext;
                  cb  <= 1'b0;
                  m_r <= mult_ext;
                  cnt <= '0;
`ifdef BOOTH_MULT_ZERO_SKIP_EN
                  if (zero_op) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     ZhighOut <= '0;
                     ZlowOut  <= '0;
                  end else
`endif
                  begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc <= shifted[2*E-1:E];
               q   <= shifted[E-1:0];
               cb  <= q[1];
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state    <= ST_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  ZhighOut <= shifted[2*WIDTH-1:WIDTH];
                  ZlowOut  <= shifted[WIDTH-1:0];
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifndef BOOTH_MULT_ZERO_SKIP_EN
   // Zero detection only matters to the skip path.
   logic unused_zero;
   assign unused_zero = zero_op;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases, random
// operands against an integer-multiply reference, handshake timing,
// ignored mid-run start, asynchronous clear, and a WIDTH=8 instance.
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] mult = '0;
   logic [31:0] multr = '0;
   logic        busy, done;
   logic [31:0] zh, zl;

   logic        start8 = 1'b0;
   logic        sgn8 = 1'b0;
   logic [7:0]  m8 = '0;
   logic [7:0]  r8 = '0;
   logic        busy8, done8;
   logic [7:0]  zh8, zl8;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(32)) dut (
      .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
      .mult(mult), .multr(multr), .busy(busy), .done(done),
      .ZhighOut(zh), .ZlowOut(zl)
   );

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .clr(clr), .start(start8), .is_signed(sgn8),
      .mult(m8), .multr(r8), .busy(busy8), .done(done8),
      .ZhighOut(zh8), .ZlowOut(zl8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Reference: plain integer multiply of the mode-extended operands.
   function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      x = s ? longint'($signed(a)) : longint'({32'b0, a});
      y = s ? longint'($signed(b)) : longint'({32'b0, b});
      return 64'(x * y);
   endfunction

   function automatic logic [15:0] ref_mul8(input logic s, input logic [7:0] a, input logic [7:0] b);
      int x, y;
      x = s ? int'($signed(a)) : int'({24'b0, a});
      y = s ? int'($signed(b)) : int'({24'b0, b});
      return 16'(x * y);
   endfunction

   // Issue one op; lat counts edges from the start edge (=1) to done seen.
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input int poke_at,
                        output logic [63:0] res, output int lat, output int bcnt);
      if (!b2b) @(negedge clk);
      start = 1'b1; is_signed = s; mult = a; multr = b;
      @(posedge clk); #1;
      start = 1'b0; mult = $urandom; multr = $urandom; is_signed = ~s;
      lat = 1; bcnt = 0;
      while (!done && lat < 200) begin
         bcnt += int'(busy);
         @(posedge clk); #1;
         lat++;
         start = (lat == poke_at);
         if (lat == poke_at) begin mult = $urandom; multr = $urandom; end
      end
      start = 1'b0;
      if (lat >= 200) chk("timeout", 64'(lat), 64'd0);
      res = {zh, zl};
   endtask

   task automatic run_chk(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input bit b2b, input int poke_at,
                          input int exp_lat);
      logic [63:0] res;
      int lat, bcnt;
      do_op(s, a, b, b2b, poke_at, res, lat, bcnt);
      chk({tag, " prod"}, res, ref_mul(s, a, b));
      chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, " busycyc"}, 64'(bcnt), 64'(exp_lat > 1 ? exp_lat - 1 : 0));
      chk({tag, " busy@done"}, 64'(busy), 64'd0);
   endtask

   task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b);
      int lat;
      @(negedge clk);
      start8 = 1'b1; sgn8 = s; m8 = a; r8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; m8 = 8'($urandom); r8 = 8'($urandom);
      lat = 1;
      while (!done8 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " prod"}, 64'({zh8, zl8}), 64'(ref_mul8(s, a, b)));
      chk({tag, " lat"}, 64'(lat), 64'd6);
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      int          seen;
      int          zlat;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst z", {zh, zl}, 64'd0);
      @(negedge clk);
      clr = 1'b0;

      run_chk("neg7x3", 1'b1, 32'hFFFF_FFF9, 32'd3, 1'b0, -1, 18);
      chk("neg7x3 const", {zh, zl}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_chk("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 18);
      chk("umax const", {zh, zl}, 64'hFFFF_FFFE_0000_0001);
      run_chk("smax", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 18);
      chk("smax const", {zh, zl}, 64'h0000_0000_0000_0001);
      run_chk("smin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, 18);
      chk("smin const", {zh, zl}, 64'h4000_0000_0000_0000);
      // Accepted in the DONE cycle of the previous op.
      run_chk("b2b", 1'b0, 32'd5, 32'd6, 1'b1, -1, 18);
      chk("b2b const", {zh, zl}, 64'd30);

      // Start pulsed mid-run must be ignored.
      run_chk("midstart", 1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0, 6, 18);

      // Asynchronous clear at step 8.
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; mult = 32'hDEAD_BEEF; multr = 32'h0BAD_F00D;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 clr = 1'b1;
      #1;
      chk("clr z", {zh, zl}, 64'd0);
      chk("clr busy", 64'(busy), 64'd0);
      chk("clr done", 64'(done), 64'd0);
      @(negedge clk);
      clr = 1'b0;
      seen = 0;
      repeat (22) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      chk("clr nodone", 64'(seen), 64'd0);
      run_chk("after clr", 1'b0, 32'd2, 32'd3, 1'b0, -1, 18);
      chk("after clr const", {zh, zl}, 64'd6);

      // Zero operand: skipped when the option is built in.
`ifdef BOOTH_MULT_ZERO_SKIP_EN
      zlat = 1;
`else
      zlat = 18;
`endif
      run_chk("zero", 1'b0, 32'd0, 32'h1234, 1'b0, -1, zlat);

      // Random operands, mixed modes, with some back-to-back.
      for (int i = 0; i < 16; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom);
         if (i % 5 == 1) a[31] = 1'b1;
         if (i % 7 == 2) b = 32'h8000_0000;
         run_chk($sformatf("rnd%0d", i), s, a, b, 1'(i % 3 == 0), -1, 18);
      end

      // Narrow instance.
      run8("w8 smin", 1'b1, 8'h80, 8'h80);
      chk("w8 const", 64'({zh8, zl8}), 64'h4000);
      for (int i = 0; i < 6; i++)
         run8($sformatf("w8 rnd%0d", i), 1'($urandom), 8'($urandom), 8'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
